// File: rtl/nibble_adder_arbiter.sv
// nibble_adder_arbiter
// Two requesters share one external 4-bit adder slice. A round-robin arbiter
// picks a requester, captures its operands, then feeds the slice one nibble
// per clock (LSB first) while rippling the carry through a register. The
// finished sum, final carry and requester id are published with a one-cycle
// done pulse and held until the next completion.
module nibble_adder_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_50MHz,
    input  logic                   rst,
    input  logic                   req0,
    input  logic [4*NIBBLES-1:0]   a0,
    input  logic [4*NIBBLES-1:0]   b0,
    input  logic                   req1,
    input  logic [4*NIBBLES-1:0]   a1,
    input  logic [4*NIBBLES-1:0]   b1,
    output logic [1:0]             gnt,
    output logic                   busy,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry,
    output logic                   done,
    output logic                   done_id
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES < 2) ? 1 : $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [W-1:0]    op_a_r;
    logic [W-1:0]    op_b_r;
    logic [W-1:0]    acc_r;
    logic [W-1:0]    acc_next_s;
    logic            carry_r;
    logic [CW-1:0]   count_r;
    logic            id_r;
    logic            last_r;
    logic            any_req_s;
    logic            pick_s;

    // One-hot grant vector for a requester id
    function automatic logic [1:0] id_to_onehot(input logic id);
        id_to_onehot = id ? 2'b10 : 2'b01;
    endfunction

    // The operand shift registers empty themselves (zero fill) as nibbles are
    // consumed, so they read as zero outside RUN and can drive the slice
    // directly from flops. The carry register is likewise cleared on exit.
    assign add_a   = op_a_r[3:0];
    assign add_b   = op_b_r[3:0];
    assign add_cin = carry_r;

    assign any_req_s = req0 | req1;

    // Round-robin choice: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        pick_s = 1'b0;
        if (req0 && req1) begin
            pick_s = ~last_r;
        end else if (req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Next accumulator value: the new sum nibble enters at the top
    generate
        if (NIBBLES == 1) begin : g_acc_single
            assign acc_next_s = add_sum;
        end else begin : g_acc_multi
            assign acc_next_s = {add_sum, acc_r[W-1:4]};
        end
    endgenerate

    // Arbitration, nibble sequencing and result publication
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            op_a_r  <= '0;
            op_b_r  <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            count_r <= '0;
            id_r    <= 1'b0;
            last_r  <= 1'b1;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            gnt  <= 2'b00;
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        op_a_r  <= pick_s ? a1 : a0;
                        op_b_r  <= pick_s ? b1 : b0;
                        acc_r   <= '0;
                        carry_r <= 1'b0;
                        count_r <= '0;
                        id_r    <= pick_s;
                        gnt     <= id_to_onehot(pick_s);
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r  <= acc_next_s;
                    op_a_r <= op_a_r >> 4'd4;
                    op_b_r <= op_b_r >> 4'd4;
                    if (count_r == LAST_CNT) begin
                        // Final nibble: publish now so done and result appear together
                        op_a_r  <= '0;
                        op_b_r  <= '0;
                        carry_r <= 1'b0;
                        result  <= acc_next_s;
                        carry   <= add_cout;
                        done    <= 1'b1;
                        done_id <= id_r;
                        state_r <= DONE;
                    end else begin
                        carry_r <= add_cout;
                        count_r <= count_r + CW'(1);
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    last_r  <= id_r;
                    state_r <= IDLE;
                end
                default: begin
                    op_a_r  <= '0;
                    op_b_r  <= '0;
                    carry_r <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_adder_arbiter.sv
// Directed bench for nibble_adder_arbiter: table of single transactions plus
// hand-written sequences for carry ripple, arbitration, reset abort and
// operand capture. The shared adder slice is modelled here.
module tb_nibble_adder_arbiter;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic           clk_50MHz = 1'b0;
    logic           rst;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic [1:0]     gnt;
    logic           busy;
    logic [3:0]     add_a, add_b, add_sum;
    logic           add_cin, add_cout;
    logic [W-1:0]   result;
    logic           carry, done, done_id;

    int tests = 0;
    int fails = 0;

    nibble_adder_arbiter #(.NIBBLES(NIBBLES)) dut (
        .clk_50MHz(clk_50MHz), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt(gnt), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .result(result), .carry(carry), .done(done), .done_id(done_id)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Shared 4-bit adder slice
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

    typedef struct {
        logic         r0;
        logic [15:0]  av0;
        logic [15:0]  bv0;
        logic         r1;
        logic [15:0]  av1;
        logic [15:0]  bv1;
        logic [1:0]   egnt;
        logic [15:0]  eres;
        logic         ecar;
        logic         eid;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(input int limit, output int n);
        logic got;
        got = 1'b0;
        n = 0;
        for (int i = 1; i <= limit && !got; i++) begin
            @(negedge clk_50MHz);
            if (gnt != 2'b00) begin
                got = 1'b1;
                n = i;
            end
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        logic got;
        got = 1'b0;
        n = 0;
        for (int i = 1; i <= limit && !got; i++) begin
            @(negedge clk_50MHz);
            if (done) begin
                got = 1'b1;
                n = i;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk_50MHz);
        req0 = v.r0; a0 = v.av0; b0 = v.bv0;
        req1 = v.r1; a1 = v.av1; b1 = v.bv1;
        wait_gnt(20, n);
        check("vec_gnt", gnt, v.egnt);
        check("vec_gnt_latency", n, 1);
        check("vec_busy", busy, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        a0 = 16'h5A5A; b0 = 16'hA5A5; a1 = 16'h3C3C; b1 = 16'hC3C3;
        wait_done(20, n);
        check("vec_done_latency", n, NIBBLES);
        check("vec_result", result, v.eres);
        check("vec_carry", carry, v.ecar);
        check("vec_done_id", done_id, v.eid);
        @(negedge clk_50MHz);
        check("vec_done_pulse", done, 1'b0);
        check("vec_result_hold", result, v.eres);
    endtask

    task automatic run_nibbles(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] sums, input logic [3:0] couts,
                               input logic [3:0] cins, input logic [15:0] eres,
                               input logic ecar);
        int n;
        @(negedge clk_50MHz);
        req0 = 1'b1; a0 = a; b0 = b; req1 = 1'b0;
        wait_gnt(20, n);
        check("nib_gnt", gnt, 2'b01);
        req0 = 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (i > 0) @(negedge clk_50MHz);
            check("nib_add_a", add_a, a[4*i +: 4]);
            check("nib_add_b", add_b, b[4*i +: 4]);
            check("nib_add_cin", add_cin, cins[i]);
            check("nib_add_sum", add_sum, sums[4*i +: 4]);
            check("nib_add_cout", add_cout, couts[i]);
            check("nib_busy", busy, 1'b1);
        end
        @(negedge clk_50MHz);
        check("nib_done", done, 1'b1);
        check("nib_result", result, eres);
        check("nib_carry", carry, ecar);
        check("nib_slice_idle", {add_a, add_b, add_cin}, 9'h000);
        @(negedge clk_50MHz);
        check("nib_done_low", done, 1'b0);
        check("nib_busy_low", busy, 1'b0);
    endtask

    task automatic reset_mid_run(input logic r0_after, input logic r1_after, input logic [1:0] exp_gnt);
        int n;
        @(negedge clk_50MHz);
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0FCD; req1 = 1'b0;
        wait_gnt(20, n);
        check("rst_pre_gnt", gnt, 2'b01);
        req0 = 1'b0;
        @(negedge clk_50MHz);
        rst = 1'b1;
        #1;
        check("rst_async_zero", {gnt, busy, add_a, add_b, add_cin, result, carry, done, done_id}, 32'h0);
        req0 = r0_after; req1 = r1_after; a1 = 16'h0F0F; b1 = 16'h0101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50MHz);
            check("rst_no_done", {done, busy}, 2'b00);
        end
        rst = 1'b0;
        wait_gnt(10, n);
        check("rst_next_gnt", gnt, exp_gnt);
        req0 = 1'b0; req1 = 1'b0;
        if (exp_gnt != 2'b00) begin
            wait_done(20, n);
            check("rst_next_done", done, 1'b1);
            check("rst_next_id", done_id, exp_gnt[1]);
        end else begin
            check("rst_result_zero", result, 16'h0000);
        end
        @(negedge clk_50MHz);
    endtask

    initial begin
        int n;
        int ng, nd;
        int gcyc[4];

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        vecs[0] = '{1'b1, 16'h1234, 16'h0FCD, 1'b0, 16'h0000, 16'h0000, 2'b01, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0001, 2'b10, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 16'h0FFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 2'b01, 16'h1000, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'h8000, 2'b10, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'hABCD, 16'h1111, 1'b0, 16'h0000, 16'h0000, 2'b01, 16'hBCDE, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 2'b10, 16'hFFFE, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'b01, 16'h0000, 1'b0, 1'b0};

        // Reset state
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        check("reset_outputs", {gnt, busy, add_a, add_b, add_cin, result, carry, done, done_id}, 32'h0);
        rst = 1'b0;
        @(negedge clk_50MHz);
        check("idle_no_gnt", {gnt, busy}, 3'b000);

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Per-nibble slice traffic
        run_nibbles(16'hFFFF, 16'h0001, 16'h0000, 4'b1111, 4'b1110, 16'h0000, 1'b1);
        run_nibbles(16'h0FFF, 16'h0001, 16'h1000, 4'b0111, 4'b1110, 16'h1000, 1'b0);

        // Operands changed after the grant are ignored
        @(negedge clk_50MHz);
        req0 = 1'b1; a0 = 16'h1111; b0 = 16'h1111; req1 = 1'b0;
        wait_gnt(20, n);
        check("capture_gnt", gnt, 2'b01);
        req0 = 1'b0; a0 = 16'hAAAA; b0 = 16'h1111;
        wait_done(20, n);
        check("capture_result", result, 16'h2222);
        @(negedge clk_50MHz);

        // Both requesting from reset: alternate 0,1,0,1 spaced NIBBLES+2
        rst = 1'b1;
        @(negedge clk_50MHz);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'h1111; b0 = 16'h0001; a1 = 16'h2222; b1 = 16'h0002;
        ng = 0; nd = 0;
        for (int k = 0; k < 4; k++) gcyc[k] = 0;
        for (int c = 0; c < 60 && nd < 4; c++) begin
            @(negedge clk_50MHz);
            if (gnt != 2'b00 && ng < 4) begin
                gcyc[ng] = c;
                check("alt_gnt", gnt, (ng % 2 == 1) ? 2'b10 : 2'b01);
                ng++;
            end
            if (done && nd < 4) begin
                check("alt_done_id", done_id, nd % 2);
                check("alt_result", result, (nd % 2 == 1) ? 16'h2224 : 16'h1112);
                nd++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("alt_grant_count", ng, 4);
        check("alt_done_count", nd, 4);
        for (int k = 1; k < 4; k++) begin
            check("alt_spacing", gcyc[k] - gcyc[k-1], NIBBLES + 2);
        end
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);

        // Reset during the second RUN cycle
        reset_mid_run(1'b1, 1'b1, 2'b01);
        reset_mid_run(1'b0, 1'b1, 2'b10);
        reset_mid_run(1'b0, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
